// File: rtl/spi_subunit_regfile.sv
// Mode-0 SPI subordinate over an 8-bit register bank: 0x0A writes, 0x0B reads.
// Defining SPI_SUB_FIFO_EN adds an outbound byte FIFO that command 0x0D reads.
module spi_subunit_regfile #(
  parameter int NUM_REGS    = 64,
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       cs,
  output logic       miso,
  input  logic       fifo_push,
  input  logic [7:0] fifo_din,
  output logic       fifo_full,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  // state    | meaning
  // S_IDLE   | cs high, miso released
  // S_CMD    | receiving command byte
  // S_ADDR   | receiving start address
  // S_WRITE  | each received byte writes a register
  // S_READ   | each byte shifts out a register
  // S_FIFO   | each byte shifts out the FIFO head
  // S_IGNORE | unknown command, wait for cs to rise

  localparam int         AW        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [8:0] NREGS     = 9'(NUM_REGS);
  localparam logic [7:0] LAST_ADDR = 8'(NUM_REGS - 1);
  localparam logic [7:0] CMD_WR    = 8'h0A;
  localparam logic [7:0] CMD_RD    = 8'h0B;
  localparam logic [7:0] CMD_FIFO  = 8'h0D;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_WRITE, S_READ, S_FIFO, S_IGNORE
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync, sync_vld;
  logic       sclk_s, mosi_s, cs_s;
  logic       sclk_d, cs_d, armed;
  logic       sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [2:0] bit_cnt;
  logic [6:0] rx;
  logic [7:0] rx_byte, shift, addr, addr_inc;
  logic [7:0] rd_rx, rd_inc, fifo_head;
  logic       is_read, byte_done, reg_we;
  logic       rx_ok, addr_ok, inc_ok;
  logic       miso_en, miso_val;
  logic [7:0] regs [1 << AW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      sync_vld  <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
      armed     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      sync_vld  <= {sync_vld[SYNC_STAGES-2:0], 1'b1};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
      // A select already low at reset release must not look like a falling edge.
      armed     <= armed | (sync_vld[SYNC_STAGES-1] & cs_s);
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = armed & cs_d & ~cs_s;

  assign rx_byte   = {rx, mosi_s};
  assign byte_done = (state != S_IDLE) && !cs_rise && sclk_rise && (bit_cnt == 3'd7);
  assign addr_inc  = (addr == LAST_ADDR) ? 8'd0 : addr + 8'd1;
  assign rx_ok     = {1'b0, rx_byte} < NREGS;
  assign addr_ok   = {1'b0, addr} < NREGS;
  assign inc_ok    = {1'b0, addr_inc} < NREGS;
  assign rd_rx     = rx_ok ? regs[rx_byte[AW-1:0]] : 8'h00;
  assign rd_inc    = inc_ok ? regs[addr_inc[AW-1:0]] : 8'h00;
  assign reg_we    = byte_done && (state == S_WRITE) && addr_ok;

`ifdef SPI_SUB_FIFO_EN
  localparam int            FW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [FW:0]   FIFO_CAP = (FW + 1)'(FIFO_DEPTH);

  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [FW-1:0] fifo_wp, fifo_rp;
  logic [FW:0] fifo_cnt;
  logic        fifo_pop_req, fifo_do_push, fifo_do_pop;

  assign fifo_pop_req = byte_done &&
                        ((state == S_FIFO) || ((state == S_CMD) && (rx_byte == CMD_FIFO)));
  assign fifo_full    = (fifo_cnt == FIFO_CAP);
  assign fifo_do_push = fifo_push & ~fifo_full;
  assign fifo_do_pop  = fifo_pop_req && (fifo_cnt != '0);
  assign fifo_head    = (fifo_cnt != '0) ? fifo_mem[fifo_rp] : 8'h00;

  always_ff @(posedge clk) begin
    if (fifo_do_push) fifo_mem[fifo_wp] <= fifo_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wp  <= '0;
      fifo_rp  <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_do_push) fifo_wp <= fifo_wp + FW'(1);
      if (fifo_do_pop) fifo_rp <= fifo_rp + FW'(1);
      fifo_cnt <= fifo_cnt + {{FW{1'b0}}, fifo_do_push} - {{FW{1'b0}}, fifo_do_pop};
    end
  end
`else
  localparam int fifo_depth_unused = FIFO_DEPTH;
  logic unused_fifo;

  assign fifo_full   = 1'b0;
  assign fifo_head   = 8'h00;
  assign unused_fifo = ^{fifo_push, fifo_din};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (cs_rise) begin
      state_nxt = S_IDLE;
    end else if (state == S_IDLE) begin
      if (cs_fall) state_nxt = S_CMD;
    end else if (byte_done) begin
      case (state)
        S_CMD: begin
          if ((rx_byte == CMD_WR) || (rx_byte == CMD_RD)) state_nxt = S_ADDR;
`ifdef SPI_SUB_FIFO_EN
          else if (rx_byte == CMD_FIFO) state_nxt = S_FIFO;
`endif
          else state_nxt = S_IGNORE;
        end
        S_ADDR:  state_nxt = is_read ? S_READ : S_WRITE;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    busy     = 1'b0;
    miso_en  = 1'b0;
    miso_val = 1'b0;
    case (state)
      S_IDLE: ;
      S_WRITE, S_READ, S_FIFO: begin
        busy     = 1'b1;
        miso_en  = 1'b1;
        miso_val = shift[7];
      end
      default: begin
        busy    = 1'b1;
        miso_en = 1'b1;
      end
    endcase
  end

  assign miso = miso_en ? miso_val : 1'bz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= 3'd0;
      rx        <= 7'd0;
      shift     <= 8'h00;
      addr      <= 8'h00;
      is_read   <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= 8'h00;
      wr_data   <= 8'h00;
    end else begin
      wr_strobe <= reg_we;
      if (reg_we) begin
        wr_addr <= addr;
        wr_data <= rx_byte;
      end
      if (state == S_IDLE) begin
        if (cs_fall) begin
          bit_cnt <= 3'd0;
          rx      <= 7'd0;
          shift   <= 8'h00;
        end
      end else if (!cs_rise) begin
        if (sclk_rise) begin
          bit_cnt <= bit_cnt + 3'd1;
          rx      <= rx_byte[6:0];
        end
        // Hold bit 7 across the byte boundary so it is valid before the first rising edge.
        if (sclk_fall && (bit_cnt != 3'd0)) shift <= {shift[6:0], 1'b0};
        if (byte_done) begin
          case (state)
            S_CMD: begin
              is_read <= (rx_byte == CMD_RD);
              if (rx_byte == CMD_FIFO) shift <= fifo_head;
            end
            S_ADDR: begin
              addr <= rx_byte;
              if (is_read) shift <= rd_rx;
            end
            S_WRITE: addr <= addr_inc;
            S_READ: begin
              shift <= rd_inc;
              addr  <= addr_inc;
            end
            S_FIFO:  shift <= fifo_head;
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < (1 << AW); i++) regs[i] <= 8'h00;
    end else if (reg_we) begin
      regs[addr[AW-1:0]] <= rx_byte;
    end
  end

endmodule

// File: tb/tb_spi_subunit_regfile.sv
// Directed and randomized SPI traffic against a behavioural register/FIFO model.
module tb_spi_subunit_regfile;
  localparam int NREGS  = 64;
  localparam int FDEPTH = 16;
  localparam int HP     = 8;
`ifdef SPI_SUB_FIFO_EN
  localparam bit FIFO_EN = 1'b1;
`else
  localparam bit FIFO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic       cs = 1'b1;
  logic       fifo_push = 1'b0;
  logic [7:0] fifo_din = 8'h00;
  wire        miso;
  logic       fifo_full, wr_strobe, busy;
  logic [7:0] wr_addr, wr_data;

  pullup (miso);

  spi_subunit_regfile #(
    .NUM_REGS(NREGS), .FIFO_DEPTH(FDEPTH), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .mosi(mosi), .cs(cs), .miso(miso),
    .fifo_push(fifo_push), .fifo_din(fifo_din), .fifo_full(fifo_full),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  int         strobe_cnt = 0;
  logic [7:0] mon_addr = 8'h00;
  logic [7:0] mon_data = 8'h00;
  int         exp_strobes = 0;
  logic [7:0] exp_addr = 8'h00;
  logic [7:0] exp_data = 8'h00;
  logic [7:0] model [256];
  logic [7:0] fifo_q [$];
  logic [7:0] wq [$];
  logic [7:0] rx;

  always @(negedge clk) begin
    if (wr_strobe === 1'b1) begin
      strobe_cnt++;
      mon_addr = wr_addr;
      mon_data = wr_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int next_addr(input int a);
    return (a == NREGS - 1) ? 0 : (a + 1) % 256;
  endfunction

  function automatic logic [7:0] model_rd(input int a);
    return (a < NREGS) ? model[a] : 8'h00;
  endfunction

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] r);
    r = 8'h00;
    for (int i = 0; i < n; i++) begin
      mosi = tx[7-i];
      repeat (HP) @(negedge clk);
      r = {r[6:0], miso};
      sclk = 1'b1;
      repeat (HP) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] r);
    spi_bits(tx, 8, r);
  endtask

  task automatic cs_start();
    cs = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (4) @(negedge clk);
    cs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_write(input int start);
    int a;
    cs_start();
    spi_byte(8'h0A, rx);
    spi_byte(8'(start), rx);
    a = start;
    foreach (wq[i]) begin
      spi_byte(wq[i], rx);
      if (a < NREGS) begin
        model[a] = wq[i];
        exp_strobes++;
        exp_addr = 8'(a);
        exp_data = wq[i];
      end
      a = next_addr(a);
    end
    cs_end();
  endtask

  task automatic do_read(input int start, input int n, input string tag);
    int a;
    cs_start();
    spi_byte(8'h0B, rx);
    spi_byte(8'(start), rx);
    a = start;
    for (int i = 0; i < n; i++) begin
      spi_byte(8'h00, rx);
      chk(tag, 32'(rx), 32'(model_rd(a)));
      a = next_addr(a);
    end
    cs_end();
  endtask

  task automatic chk_strobes(input string tag);
    chk({tag, "_cnt"}, 32'(strobe_cnt), 32'(exp_strobes));
    chk({tag, "_addr"}, 32'(mon_addr), 32'(exp_addr));
    chk({tag, "_data"}, 32'(mon_data), 32'(exp_data));
  endtask

  task automatic push(input logic [7:0] d);
    fifo_din = d;
    fifo_push = 1'b1;
    @(negedge clk);
    fifo_push = 1'b0;
    if (FIFO_EN && fifo_q.size() < FDEPTH) fifo_q.push_back(d);
  endtask

  task automatic do_fifo_read(input int n, input string tag);
    logic [7:0] e;
    cs_start();
    spi_byte(8'h0D, rx);
    for (int i = 0; i < n; i++) begin
      spi_byte(8'h00, rx);
      e = (fifo_q.size() > 0) ? fifo_q.pop_front() : 8'h00;
      chk(tag, 32'(rx), 32'(e));
    end
    cs_end();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_strobe"}, 32'(wr_strobe), 32'd0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
    chk({tag, "_fifo_full"}, 32'(fifo_full), 32'd0);
    chk({tag, "_miso_hiz"}, 32'(miso), 32'd1);
  endtask

  initial begin
    int start, len;
    for (int i = 0; i < 256; i++) model[i] = 8'h00;

    // Power-on reset
    repeat (4) @(negedge clk);
    chk_reset("por");
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Single write, then read back including an unwritten neighbour
    wq = {};
    wq.push_back(8'hA5);
    do_write(5);
    chk_strobes("wr05");
    do_read(5, 2, "rd05");

    // Burst write across the top of the register space
    wq = {};
    wq.push_back(8'h11);
    wq.push_back(8'h22);
    do_write(8'h3F);
    chk_strobes("wrap");
    do_read(8'h3F, 2, "rd_wrap");

    // Randomized bursts, some starting beyond NUM_REGS
    for (int it = 0; it < 6; it++) begin
      start = int'($urandom_range(0, 79));
      len = int'($urandom_range(1, 4));
      wq = {};
      for (int k = 0; k < len; k++) wq.push_back(8'($urandom_range(0, 255)));
      do_write(start);
      chk_strobes("rand_wr");
      do_read(start, len + 1, "rand_rd");
    end

    // Unknown command: miso held low, no writes
    cs_start();
    spi_byte(8'h55, rx);
    chk("bad_cmd_miso", 32'(rx), 32'd0);
    chk("bad_cmd_busy", 32'(busy), 32'd1);
    spi_byte(8'hFF, rx);
    chk("ignore_miso", 32'(rx), 32'd0);
    cs_end();
    chk("ignore_strobes", 32'(strobe_cnt), 32'(exp_strobes));

    // Partial data byte aborted by cs
    wq = {};
    wq.push_back(8'h5A);
    do_write(8'h10);
    cs_start();
    spi_byte(8'h0A, rx);
    spi_byte(8'h10, rx);
    spi_bits(8'hFF, 4, rx);
    repeat (4) @(negedge clk);
    cs = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_strobes", 32'(strobe_cnt), 32'(exp_strobes));
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_miso_hiz", 32'(miso), 32'd1);
    do_read(8'h10, 1, "abort_rd");

    // FIFO: two entries then empty; then fill to capacity with one dropped push
    chk("fifo_empty_flag", 32'(fifo_full), 32'd0);
    push(8'h01);
    push(8'h02);
    do_fifo_read(3, "fifo_rd");
    for (int k = 0; k < FDEPTH - 1; k++) push(8'($urandom_range(0, 255)));
    chk("fifo_almost", 32'(fifo_full), 32'd0);
    push(8'($urandom_range(0, 255)));
    chk("fifo_full", 32'(fifo_full), 32'(FIFO_EN));
    push(8'hEE);
    chk("fifo_full_drop", 32'(fifo_full), 32'(FIFO_EN));
    do_fifo_read(FDEPTH + 1, "fifo_drain");
    chk("fifo_drained", 32'(fifo_full), 32'd0);
    push(8'h33);
    push(8'h44);

    // Reset in the middle of a read, with cs held low across release
    cs_start();
    spi_byte(8'h0B, rx);
    spi_byte(8'h05, rx);
    spi_bits(8'h00, 4, rx);
    rst_n = 1'b0;
    fifo_q = {};
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset("mid_rst");
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    spi_byte(8'h0A, rx);
    spi_byte(8'h07, rx);
    chk("stale_cs_busy", 32'(busy), 32'd0);
    chk("stale_cs_miso_hiz", 32'(miso), 32'd1);
    spi_byte(8'h77, rx);
    cs_end();
    chk("stale_cs_strobes", 32'(strobe_cnt), 32'(exp_strobes));
    do_read(5, 2, "post_rst_rd");
    do_fifo_read(1, "post_rst_fifo");
    wq = {};
    wq.push_back(8'h77);
    do_write(7);
    chk_strobes("post_rst_wr");
    do_read(7, 1, "post_rst_rd07");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
